// File: rtl/abs_diff_pkg.sv
// Shared definitions for the abs_diff_acc block: state encoding and width helpers.
package abs_diff_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ACC  = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic int unsigned cnt_w(input int unsigned max_beats);
        return $clog2(max_beats + 1);
    endfunction

    function automatic int unsigned sad_w(input int unsigned w,
                                          input int unsigned lanes,
                                          input int unsigned max_beats);
        return w + $clog2(lanes) + $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/abs_diff_lane.sv
// One lane of |a-b|; in approximate mode both operands lose their low TRUNC bits first.
module abs_diff_lane #(
    parameter int unsigned W     = 4,
    parameter int unsigned TRUNC = 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         approx_i,
    output logic [W-1:0] diff_o
);

    logic [W-1:0] mask;
    logic [W-1:0] a_m;
    logic [W-1:0] b_m;

    always_comb begin
        mask = '1;
        if (approx_i) begin
            mask = mask << TRUNC;
        end
        a_m = a_i & mask;
        b_m = b_i & mask;
        diff_o = (a_m >= b_m) ? (a_m - b_m) : (b_m - a_m);
    end

endmodule

// File: rtl/abs_diff_acc.sv
// Two-stage sum-of-absolute-differences accumulator with per-block max, beat count,
// overflow saturation and an optional truncated-operand mode.
module abs_diff_acc
    import abs_diff_pkg::*;
#(
    parameter int unsigned W         = 4,
    parameter int unsigned LANES     = 2,
    parameter int unsigned MAX_BEATS = 15,
    parameter int unsigned TRUNC     = 1,
    localparam int unsigned CW       = cnt_w(MAX_BEATS),
    localparam int unsigned SW       = sad_w(W, LANES, MAX_BEATS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_a,
    input  logic [LANES*W-1:0] in_b,
    input  logic               in_last,
    input  logic               approx_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SW-1:0]      out_sad,
    output logic [W-1:0]       out_max,
    output logic [CW-1:0]      out_beats,
    output logic               out_ovf,
    output logic               out_approx
);

    logic         adv;
    logic         accept;
    logic         eff_approx;
    logic [W-1:0] lane_diff [LANES];

    // Stage 1 tracks block boundaries itself so truncation is known before the first beat lands.
    logic         first_q;
    logic         blk_approx_q;
    logic         s1_valid_q;
    logic         s1_last_q;
    logic         s1_approx_q;
    logic [W-1:0] s1_diff_q [LANES];

    state_t        state_q, state_d;
    logic [SW-1:0] sad_q, sad_d;
    logic [W-1:0]  max_q, max_d;
    logic [CW-1:0] beats_q, beats_d;
    logic          ovf_q, ovf_d;
    logic          approx_q, approx_d;

    logic [SW-1:0] beat_sum;
    logic [W-1:0]  beat_max;

    always_comb begin
        adv        = (state_q != DONE) || out_ready;
        in_ready   = adv && rst_n;
        accept     = in_valid && in_ready;
        eff_approx = first_q ? approx_en : blk_approx_q;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        abs_diff_lane #(
            .W     (W),
            .TRUNC (TRUNC)
        ) u_lane (
            .a_i      (in_a[g*W +: W]),
            .b_i      (in_b[g*W +: W]),
            .approx_i (eff_approx),
            .diff_o   (lane_diff[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_q      <= 1'b1;
            blk_approx_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_approx_q  <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_diff_q[i] <= '0;
            end
        end else if (adv) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_diff_q    <= lane_diff;
                s1_last_q    <= in_last;
                s1_approx_q  <= eff_approx;
                first_q      <= in_last;
                blk_approx_q <= eff_approx;
            end
        end
    end

    always_comb begin
        beat_sum = '0;
        beat_max = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            beat_sum = beat_sum + SW'(s1_diff_q[i]);
            if (s1_diff_q[i] > beat_max) begin
                beat_max = s1_diff_q[i];
            end
        end

        state_d  = state_q;
        sad_d    = sad_q;
        max_d    = max_q;
        beats_d  = beats_q;
        ovf_d    = ovf_q;
        approx_d = approx_q;

        if (adv) begin
            if (s1_valid_q) begin
                state_d = s1_last_q ? DONE : ACC;
                // A beat arriving in IDLE or DONE opens a new block and never adds to the old one.
                if (state_q != ACC) begin
                    sad_d    = beat_sum;
                    max_d    = beat_max;
                    beats_d  = CW'(1);
                    ovf_d    = 1'b0;
                    approx_d = s1_approx_q;
                end else begin
                    if (beat_max > max_q) begin
                        max_d = beat_max;
                    end
                    if (beats_q == CW'(MAX_BEATS)) begin
                        ovf_d = 1'b1;
                        sad_d = '1;
                    end else begin
                        beats_d = beats_q + 1'b1;
                        sad_d   = sad_q + beat_sum;
                    end
                end
            end else if (state_q == DONE) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sad_q    <= '0;
            max_q    <= '0;
            beats_q  <= '0;
            ovf_q    <= 1'b0;
            approx_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sad_q    <= sad_d;
            max_q    <= max_d;
            beats_q  <= beats_d;
            ovf_q    <= ovf_d;
            approx_q <= approx_d;
        end
    end

    always_comb begin
        out_valid  = (state_q == DONE);
        out_sad    = sad_q;
        out_max    = max_q;
        out_beats  = beats_q;
        out_ovf    = ovf_q;
        out_approx = approx_q;
    end

endmodule

// File: tb/tb_abs_diff_acc.sv
// Bench for abs_diff_acc: directed vector table, hand-written corner sequences and a
// randomized run scored against a block-level behavioural model.
module tb_abs_diff_acc;

    localparam int unsigned W         = 4;
    localparam int unsigned LANES     = 2;
    localparam int unsigned MAX_BEATS = 15;
    localparam int unsigned TRUNC     = 1;
    localparam int unsigned CW        = 4;
    localparam int unsigned SW        = 9;
    localparam int unsigned SAT       = (1 << SW) - 1;

    typedef struct {
        logic [W-1:0] a0;
        logic [W-1:0] a1;
        logic [W-1:0] b0;
        logic [W-1:0] b1;
        logic         ap;
        int unsigned  sad;
        int unsigned  mx;
    } vec_t;

    typedef struct {
        logic [LANES*W-1:0] a;
        logic [LANES*W-1:0] b;
        logic               ap;
    } beat_t;

    typedef struct {
        int unsigned sad;
        int unsigned mx;
        int unsigned beats;
        int unsigned ovf;
        int unsigned ap;
    } res_t;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [LANES*W-1:0] in_a;
    logic [LANES*W-1:0] in_b;
    logic               in_last;
    logic               approx_en;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [SW-1:0]      out_sad;
    logic [W-1:0]       out_max;
    logic [CW-1:0]      out_beats;
    logic               out_ovf;
    logic               out_approx;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned ready_mode = 1;

    beat_t       cur[$];
    res_t        expq[$];
    int unsigned seen_beats[$];
    res_t        e;
    vec_t        vecs[7];

    abs_diff_acc #(
        .W         (W),
        .LANES     (LANES),
        .MAX_BEATS (MAX_BEATS),
        .TRUNC     (TRUNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .approx_en  (approx_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sad    (out_sad),
        .out_max    (out_max),
        .out_beats  (out_beats),
        .out_ovf    (out_ovf),
        .out_approx (out_approx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        case (ready_mode)
            0:       out_ready <= 1'b0;
            1:       out_ready <= 1'b1;
            default: out_ready <= 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Block result from first principles: mode from the first beat, count and sum saturate past MAX_BEATS.
    function automatic res_t model(input beat_t q[$]);
        res_t        r;
        int unsigned total = 0;
        int unsigned mx = 0;
        int unsigned av, bv, d;
        logic        ap;
        ap = q[0].ap;
        foreach (q[k]) begin
            for (int l = 0; l < int'(LANES); l++) begin
                av = int'(q[k].a[l*W +: W]);
                bv = int'(q[k].b[l*W +: W]);
                if (ap) begin
                    av = (av >> TRUNC) << TRUNC;
                    bv = (bv >> TRUNC) << TRUNC;
                end
                d = (av > bv) ? av - bv : bv - av;
                total += d;
                if (d > mx) mx = d;
            end
        end
        r.ovf   = (q.size() > MAX_BEATS) ? 1 : 0;
        r.beats = (q.size() > MAX_BEATS) ? MAX_BEATS : q.size();
        r.sad   = (q.size() > MAX_BEATS) ? SAT : total;
        r.mx    = mx;
        r.ap    = int'(ap);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            cur.delete();
            expq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("sb_unexpected_result", 32'(out_valid), 0);
                end else begin
                    e = expq.pop_front();
                    check("sb_sad",    32'(out_sad),    e.sad);
                    check("sb_max",    32'(out_max),    e.mx);
                    check("sb_beats",  32'(out_beats),  e.beats);
                    check("sb_ovf",    32'(out_ovf),    e.ovf);
                    check("sb_approx", 32'(out_approx), e.ap);
                    seen_beats.push_back(32'(out_beats));
                end
            end
            if (in_valid && in_ready) begin
                cur.push_back('{a: in_a, b: in_b, ap: approx_en});
                if (in_last) begin
                    expq.push_back(model(cur));
                    cur.delete();
                end
            end
        end
    end

    task automatic drive_beat(input logic [7:0] a, input logic [7:0] b,
                              input logic last, input logic ap);
        logic        acc;
        int unsigned n;
        in_a = a; in_b = b; in_last = last; approx_en = ap; in_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
                acc = 1'b1;
            end
        end
    endtask

    task automatic wait_valid();
        int unsigned n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_valid", 32'(out_valid), 1);
    endtask

    initial begin
        vecs[0] = '{4'd9,  4'd3,  4'd2,  4'd7,  1'b0, 11, 7};
        vecs[1] = '{4'd9,  4'd3,  4'd2,  4'd7,  1'b1, 10, 6};
        vecs[2] = '{4'd0,  4'd0,  4'd0,  4'd0,  1'b0, 0,  0};
        vecs[3] = '{4'd15, 4'd0,  4'd0,  4'd15, 1'b0, 30, 15};
        vecs[4] = '{4'd15, 4'd0,  4'd0,  4'd15, 1'b1, 28, 14};
        vecs[5] = '{4'd5,  4'd5,  4'd5,  4'd4,  1'b1, 0,  0};
        vecs[6] = '{4'd7,  4'd12, 4'd10, 4'd3,  1'b0, 12, 9};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; approx_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready",  32'(in_ready),  0);
        check("rst_out_sad",   32'(out_sad),   0);
        check("rst_out_beats", 32'(out_beats), 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Single-beat blocks: exact two-cycle latency and result values.
        for (int i = 0; i < 7; i++) begin
            drive_beat({vecs[i].a1, vecs[i].a0}, {vecs[i].b1, vecs[i].b0}, 1'b1, vecs[i].ap);
            in_valid = 1'b0;
            check("vec_lat_early", 32'(out_valid), 0);
            @(posedge clk);
            #1;
            check("vec_lat_valid", 32'(out_valid),  1);
            check("vec_sad",       32'(out_sad),    vecs[i].sad);
            check("vec_max",       32'(out_max),    vecs[i].mx);
            check("vec_beats",     32'(out_beats),  1);
            check("vec_ovf",       32'(out_ovf),    0);
            check("vec_approx",    32'(out_approx), 32'(vecs[i].ap));
        end
        repeat (2) @(posedge clk);
        #1;

        // Stall in DONE with a new beat waiting.
        ready_mode = 0;
        drive_beat({4'd2, 4'd1}, 8'h00, 1'b0, 1'b0);
        drive_beat({4'd0, 4'd3}, {4'd1, 4'd0}, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_valid();
        in_a = {4'd1, 4'd1}; in_b = 8'h00; in_last = 1'b0; approx_en = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready",  32'(in_ready),   0);
            check("stall_out_valid", 32'(out_valid),  1);
            check("stall_sad",       32'(out_sad),    7);
            check("stall_max",       32'(out_max),    3);
            check("stall_beats",     32'(out_beats),  2);
            check("stall_approx",    32'(out_approx), 0);
        end
        ready_mode = 1;
        drive_beat({4'd1, 4'd1}, 8'h00, 1'b0, 1'b0);
        drive_beat({4'd1, 4'd1}, 8'h00, 1'b0, 1'b1);
        drive_beat({4'd1, 4'd1}, 8'h00, 1'b1, 1'b0);
        in_valid = 1'b0;
        wait_valid();
        check("post_stall_beats", 32'(out_beats), 3);
        check("post_stall_sad",   32'(out_sad),   6);
        repeat (2) @(posedge clk);
        #1;

        // Beat-count overflow.
        for (int i = 0; i < 16; i++) begin
            drive_beat(8'hFF, 8'h00, (i == 15), 1'b0);
        end
        in_valid = 1'b0;
        wait_valid();
        check("ovf_beats", 32'(out_beats), 15);
        check("ovf_flag",  32'(out_ovf),   1);
        check("ovf_sad",   32'(out_sad),   SAT);
        check("ovf_max",   32'(out_max),   15);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back blocks of 3 and 2 beats.
        seen_beats.delete();
        drive_beat({4'd1, 4'd4}, {4'd5, 4'd1}, 1'b0, 1'b0);
        drive_beat({4'd2, 4'd6}, {4'd0, 4'd9}, 1'b0, 1'b0);
        drive_beat({4'd8, 4'd8}, {4'd8, 4'd0}, 1'b1, 1'b0);
        drive_beat({4'd3, 4'd2}, {4'd1, 4'd7}, 1'b0, 1'b1);
        drive_beat({4'd0, 4'd15}, {4'd13, 4'd0}, 1'b1, 1'b0);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("b2b_results", seen_beats.size(), 2);
        if (seen_beats.size() == 2) begin
            check("b2b_beats0", seen_beats[0], 3);
            check("b2b_beats1", seen_beats[1], 2);
        end

        // Reset in the middle of a block.
        drive_beat({4'd9, 4'd9}, 8'h00, 1'b0, 1'b0);
        drive_beat({4'd9, 4'd9}, 8'h00, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_valid",  32'(out_valid),  0);
        check("midrst_sad",    32'(out_sad),    0);
        check("midrst_max",    32'(out_max),    0);
        check("midrst_beats",  32'(out_beats),  0);
        check("midrst_ovf",    32'(out_ovf),    0);
        check("midrst_approx", 32'(out_approx), 0);
        check("midrst_ready",  32'(in_ready),   1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_result", 32'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        drive_beat({4'd3, 4'd9}, {4'd7, 4'd2}, 1'b1, 1'b0);
        in_valid = 1'b0;
        wait_valid();
        check("after_rst_beats", 32'(out_beats), 1);
        check("after_rst_sad",   32'(out_sad),   11);
        repeat (2) @(posedge clk);
        #1;

        // Randomized blocks under random out_ready.
        ready_mode = 2;
        for (int blk = 0; blk < 60; blk++) begin
            int unsigned len;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 19) : $urandom_range(1, 6);
            for (int unsigned j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                drive_beat(8'($urandom), 8'($urandom), (j == len - 1), 1'($urandom_range(0, 1)));
            end
        end
        in_valid = 1'b0;
        ready_mode = 1;
        for (int i = 0; i < 100 && expq.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_pending", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/abs_diff_acc.md
ABS_DIFF_ACC -- requirements
Module: abs_diff_acc

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the unsigned operand width per lane.
REQ-002 The block SHALL have parameter LANES, default 2, giving the operand pairs accepted per beat.
REQ-003 The block SHALL have parameter MAX_BEATS, default 15, giving the largest beat count per block.
REQ-004 The block SHALL have parameter TRUNC, default 1, giving the LSBs zeroed in approximate mode (0 <= TRUNC < W).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): the input beat handshake.
REQ-008 The block SHALL have ports in_a and in_b, input, LANES*W bits each: the operands, with lane i at bits [i*W +: W].
REQ-009 The block SHALL have port in_last, input, 1 bit: marks the final beat of a block.
REQ-010 The block SHALL have port approx_en, input, 1 bit: requests truncated-operand mode, sampled on the first beat of a block.
REQ-011 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): the result handshake.
REQ-012 The block SHALL have port out_sad, output, SW = W+clog2(LANES)+clog2(MAX_BEATS+1) bits: the block sum of absolute differences.
REQ-013 The block SHALL have port out_max, output, W bits: the largest single-lane absolute difference in the block.
REQ-014 The block SHALL have port out_beats, output, clog2(MAX_BEATS+1) bits: the number of beats accepted in the block.
REQ-015 The block SHALL have ports out_ovf (output, 1), flagging beat overflow, and out_approx (output, 1), the approx_en value captured for the block.

Function
REQ-016 A beat SHALL be accepted when in_valid and in_ready are both 1.
REQ-017 The pipeline advance condition SHALL be adv = !out_valid || out_ready, with in_ready = adv while rst_n = 1.
REQ-018 Stage 1 SHALL register per-lane |a-b| for each accepted beat, only when adv = 1.
REQ-019 In approximate mode, stage 1 SHALL zero the low TRUNC bits of both operands before subtracting.
REQ-020 Stage 2 SHALL add the lane sum and update the maximum, beat count and accumulator, only when adv = 1.
REQ-021 The state machine SHALL have the states IDLE, ACC and DONE.
REQ-022 IDLE SHALL go to ACC when the first beat reaches stage 2, and SHALL go to DONE instead if that beat carries last.
REQ-023 ACC SHALL go to DONE when the last beat reaches stage 2.
REQ-024 DONE SHALL go to IDLE on out_ready, or to ACC (or DONE if that beat carries last) when a new beat reaches stage 2 in the same cycle; that beat SHALL load the accumulator fresh and never add to the prior block.
REQ-025 out_valid SHALL be 1 exactly in DONE, so out_valid rises 2 cycles after the last beat is accepted, with no stall.
REQ-026 All out_* values SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-027 A last beat SHALL be accepted in the same cycle as the result handshake, and no beat SHALL be lost or duplicated under any out_ready pattern.
REQ-028 The beat count SHALL saturate at MAX_BEATS; when a beat would exceed it, out_ovf SHALL be 1 and out_sad SHALL saturate at all-ones for that block.
REQ-029 approx_en SHALL be ignored on non-first beats, and the value captured on the first beat SHALL be reported on out_approx.
REQ-030 A single-beat block SHALL report that beat's lane sum, with out_beats = 1.

Reset
REQ-031 While rst_n = 0 at a clk edge, the block SHALL enter IDLE, clear the stage valids and accumulators, and set out_valid, out_sad, out_max, out_beats, out_ovf and out_approx to 0.
REQ-032 in_ready SHALL be 0 while rst_n = 0, and SHALL be 1 in the first cycle after release.
REQ-033 Reset mid-block SHALL discard partial results; the first beat after reset SHALL start a new block.

Structure
REQ-034 Shared package abs_diff_pkg SHALL hold the state enum and the SW and count-width helper functions.
REQ-035 A sub-module abs_diff_lane SHALL compute one lane's |a-b| with optional truncation, instanced LANES times.

Verification (W=4, LANES=2, MAX_BEATS=15, TRUNC=1)
REQ-036 The bench SHALL check a single beat a=(9,3), b=(2,7), last, approx off -> out_valid 2 cycles later; sad=11, max=7, beats=1, ovf=0.
REQ-037 The bench SHALL check the same beat with approx_en=1 -> sad=10, max=6, out_approx=1.
REQ-038 The bench SHALL check out_ready held 0 for 5 cycles during DONE with in_valid held 1 -> in_ready=0 and outputs stable; after release, every beat is counted exactly once.
REQ-039 The bench SHALL check 16 beats of a=(15,15), b=(0,0), last on the 16th -> beats=15, ovf=1, sad=511.
REQ-040 The bench SHALL check back-to-back blocks (3 beats then 2 beats, out_ready=1) -> two results with independent sums and beat counts 3 and 2.
REQ-041 The bench SHALL check rst_n pulsed low for 1 cycle after 2 of 4 beats -> no result, all outputs 0; the next 1-beat block reports beats=1.
